// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : timer_pkg
//  Purpose  : Shared definitions for the memory-mapped countdown timer:
//             FSM state encoding, register word offsets, MODE values and
//             the CTRL register layout.
//  Revision : 1.0 - initial release
// ============================================================================
package timer_pkg;

  // Countdown sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  // Word offsets (bus address bits [3:2]).
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  // MODE field values; 2 and 3 fall back to one-shot behaviour.
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  // CTRL bit positions.
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;
  localparam int CTRL_W        = 4;

  // Packed view of CTRL; field order matches the bit positions above.
  typedef struct packed {
    logic       im;    // [3] interrupt mask (1 = interrupt enabled)
    logic [1:0] mode;  // [2:1]
    logic       en;    // [0] counter enable
  } ctrl_t;

  // Only MODE 1 reloads; every other encoding behaves as one-shot.
  function automatic logic is_reload(input logic [1:0] mode);
    return (mode == MODE_RELOAD);
  endfunction

endpackage : timer_pkg
`default_nettype wire

// File: rtl/timer_dev.sv
`default_nettype none
// ============================================================================
//  Module   : timer_dev
//  Purpose  : Memory-mapped 32-bit countdown timer with one-shot and
//             auto-reload modes and a maskable interrupt request.
//
//  Ports    : clk    - system clock
//             reset  - synchronous active-high reset
//             sel    - bridge chip-select for this device
//             we     - write enable (qualified by sel)
//             addr   - word offset (bus address bits [3:2])
//             wd     - write data
//             rd     - read data, combinational, independent of sel
//             irq    - interrupt request to the CPU
//
//  Register map (word offset):
//             0 CTRL   : [0] EN, [2:1] MODE, [3] IM, upper bits read 0
//             1 PRESET : reload value
//             2 COUNT  : current count (read-only)
//             3 reserved, reads 0, writes ignored
//  Revision : 1.0 - initial release
// ============================================================================
module timer_dev
  import timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [CNT_W-1:0] wd,
  output logic [CNT_W-1:0] rd,
  output logic             irq
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e           state_q,   state_d;
  ctrl_t            ctrl_q,    ctrl_d;
  logic [CNT_W-1:0] preset_q,  preset_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic             pending_q, pending_d;

  logic bus_wr;
  logic ctrl_wr;
  logic fsm_clr_en;
  logic fsm_set_pend;

  assign bus_wr  = sel & we;
  assign ctrl_wr = bus_wr & (addr == ADDR_CTRL);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= '0;
      preset_q  <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer: next state and count update
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    fsm_clr_en   = 1'b0;
    fsm_set_pend = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_q.en) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        // A disable that lands while loading aborts the load; COUNT holds.
        if (!ctrl_q.en) begin
          state_d = ST_IDLE;
        end else begin
          count_d = preset_q;
          state_d = ST_CNT;
        end
      end

      ST_CNT: begin
        if (!ctrl_q.en) begin
          state_d = ST_IDLE;
        end else if (count_q == '0) begin
          state_d = ST_INT;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end

      ST_INT: begin
        if (is_reload(ctrl_q.mode) && ctrl_q.en) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
          // One-shot expiry latches the interrupt and stops the timer.
          if (!is_reload(ctrl_q.mode)) begin
            fsm_clr_en   = 1'b1;
            fsm_set_pend = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Register file update (bus writes merged with sequencer side effects)
  // --------------------------------------------------------------------------
  always_comb begin
    ctrl_d    = ctrl_q;
    preset_d  = preset_q;
    pending_d = pending_q;

    if (bus_wr) begin
      unique case (addr)
        ADDR_CTRL: begin
          ctrl_d    = ctrl_t'(wd[CTRL_W-1:0]);
          pending_d = 1'b0;
        end
        ADDR_PRESET: preset_d = wd;
        default:     ; // COUNT is read-only, reserved slot ignores writes
      endcase
    end

    // The CPU's CTRL write takes priority over the expiry auto-disable.
    if (fsm_clr_en && !ctrl_wr) begin
      ctrl_d.en = 1'b0;
    end

    // An expiry landing with a CTRL write must not be lost: set beats clear.
    if (fsm_set_pend) begin
      pending_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Read mux and interrupt output
  // --------------------------------------------------------------------------
  always_comb begin
    rd = '0;
    unique case (addr)
      ADDR_CTRL:   rd = {{(CNT_W-CTRL_W){1'b0}}, ctrl_q};
      ADDR_PRESET: rd = preset_q;
      ADDR_COUNT:  rd = count_q;
      default:     rd = '0;
    endcase
  end

  // Auto-reload gives a one-cycle pulse (INT only); one-shot holds via pending.
  assign irq = ctrl_q.im & ((state_q == ST_INT) | pending_q);

endmodule : timer_dev
`default_nettype wire

// File: tb/tb_timer_dev.sv
`default_nettype none
// ============================================================================
//  Module   : tb_timer_dev
//  Purpose  : Self-checking bench for timer_dev: a table of bus vectors plus
//             hand-written multi-cycle sequences whose per-cycle expected
//             COUNT/irq values are queued before stimulus and popped as the
//             DUT produces them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_timer_dev;
  import timer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  timer_dev #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .we    (we),
    .addr  (addr),
    .wd    (wd),
    .rd    (rd),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // Per-cycle expectation for the multi-cycle sequences.
  typedef struct {
    logic [31:0] cnt;
    bit          chk_cnt;
    logic        irq;
  } exp_t;

  exp_t sb[$];

  // One bus access followed by a readback.
  typedef struct {
    logic        sel;
    logic        we;
    logic [1:0]  waddr;
    logic [31:0] wd;
    logic [1:0]  raddr;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_drive(input logic s, input logic w, input logic [1:0] a, input logic [31:0] d);
    sel  = s;
    we   = w;
    addr = a;
    wd   = d;
    @(posedge clk);
    #1;
    sel = 1'b0;
    we  = 1'b0;
    wd  = '0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_drive(1'b1, 1'b1, a, d);
  endtask

  task automatic read_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check32(name, rd, exp);
  endtask

  task automatic irq_chk(input string name, input logic exp);
    check32(name, {31'b0, irq}, {31'b0, exp});
  endtask

  task automatic sb_push(input logic [31:0] c, input bit cc, input logic i);
    exp_t e;
    e.cnt     = c;
    e.chk_cnt = cc;
    e.irq     = i;
    sb.push_back(e);
  endtask

  // Compare one queued expectation per clock, starting in the current cycle.
  task automatic sb_drain(input string name);
    exp_t e;
    int   k;
    k = 0;
    while (sb.size() > 0) begin
      e    = sb.pop_front();
      addr = ADDR_COUNT;
      #1;
      if (e.chk_cnt) check32($sformatf("%s count[%0d]", name, k), rd, e.cnt);
      irq_chk($sformatf("%s irq[%0d]", name, k), e.irq);
      k++;
      tick();
    end
  endtask

  task automatic all_zero_chk(input string name);
    read_chk({name, " ctrl"},   ADDR_CTRL,   32'h0);
    read_chk({name, " preset"}, ADDR_PRESET, 32'h0);
    read_chk({name, " count"},  ADDR_COUNT,  32'h0);
    read_chk({name, " rsvd"},   ADDR_RSVD,   32'h0);
    irq_chk({name, " irq"}, 1'b0);
  endtask

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;

    vecs[0] = '{1'b1, 1'b1, ADDR_PRESET, 32'h0000_1234, ADDR_PRESET, 32'h0000_1234};
    vecs[1] = '{1'b1, 1'b1, ADDR_COUNT,  32'h0000_0055, ADDR_COUNT,  32'h0000_0000};
    vecs[2] = '{1'b1, 1'b1, ADDR_RSVD,   32'h0000_FFFF, ADDR_RSVD,   32'h0000_0000};
    vecs[3] = '{1'b0, 1'b1, ADDR_PRESET, 32'h0000_DEAD, ADDR_PRESET, 32'h0000_1234};
    vecs[4] = '{1'b1, 1'b0, ADDR_PRESET, 32'h0000_BEEF, ADDR_PRESET, 32'h0000_1234};
    vecs[5] = '{1'b1, 1'b1, ADDR_CTRL,   32'hFFFF_FFF4, ADDR_CTRL,   32'h0000_0004};
    vecs[6] = '{1'b1, 1'b1, ADDR_CTRL,   32'h0000_0000, ADDR_CTRL,   32'h0000_0000};
    vecs[7] = '{1'b1, 1'b1, ADDR_PRESET, 32'h0000_0000, ADDR_PRESET, 32'h0000_0000};

    reset = 1'b1;
    sel   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wd    = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // ---- Reset state ----
    all_zero_chk("reset");

    // ---- One-shot, PRESET=3, CTRL=0x9 ----
    bus_write(ADDR_PRESET, 32'd3);
    sb_push(0, 1, 0); sb_push(0, 1, 0); sb_push(3, 1, 0); sb_push(2, 1, 0);
    sb_push(1, 1, 0); sb_push(0, 1, 0); sb_push(0, 1, 1); sb_push(0, 1, 1);
    sb_push(0, 1, 1);
    bus_write(ADDR_CTRL, 32'h9);
    sb_drain("oneshot");
    read_chk("oneshot ctrl after expiry", ADDR_CTRL, 32'h8);
    bus_write(ADDR_CTRL, 32'h8);
    irq_chk("oneshot irq cleared", 1'b0);

    // ---- Bus edge cases ----
    for (int i = 0; i < 8; i++) begin
      bus_drive(vecs[i].sel, vecs[i].we, vecs[i].waddr, vecs[i].wd);
      read_chk($sformatf("vec%0d rd", i), vecs[i].raddr, vecs[i].exp_rd);
      irq_chk($sformatf("vec%0d irq", i), 1'b0);
    end

    // ---- PRESET=0: irq after the third edge following the enable ----
    bus_write(ADDR_PRESET, 32'd0);
    sb_push(0, 1, 0); sb_push(0, 1, 0); sb_push(0, 1, 0); sb_push(0, 1, 1);
    bus_write(ADDR_CTRL, 32'h9);
    sb_drain("preset0");
    read_chk("preset0 ctrl after expiry", ADDR_CTRL, 32'h8);
    irq_chk("preset0 irq held", 1'b1);
    bus_write(ADDR_CTRL, 32'h0);
    irq_chk("preset0 irq cleared", 1'b0);

    // ---- Auto-reload, PRESET=2, CTRL=0xB: pulse every 5 cycles ----
    bus_write(ADDR_PRESET, 32'd2);
    sb_push(0, 1, 0); sb_push(0, 1, 0); sb_push(2, 1, 0); sb_push(1, 1, 0);
    sb_push(0, 1, 0); sb_push(0, 1, 1); sb_push(0, 1, 0); sb_push(2, 1, 0);
    sb_push(1, 1, 0); sb_push(0, 1, 0); sb_push(0, 1, 1); sb_push(0, 1, 0);
    bus_write(ADDR_CTRL, 32'hB);
    sb_drain("reload");
    read_chk("reload ctrl keeps EN", ADDR_CTRL, 32'hB);
    bus_write(ADDR_CTRL, 32'h0);
    tick();
    tick();

    // ---- Masked one-shot, PRESET=1, CTRL=0x1 ----
    bus_write(ADDR_PRESET, 32'd1);
    sb_push(0, 0, 0); sb_push(0, 0, 0); sb_push(1, 1, 0); sb_push(0, 1, 0);
    sb_push(0, 1, 0); sb_push(0, 1, 0);
    bus_write(ADDR_CTRL, 32'h1);
    sb_drain("mask");
    read_chk("mask ctrl after expiry", ADDR_CTRL, 32'h0);
    bus_write(ADDR_CTRL, 32'h8);
    irq_chk("mask unmask irq", 1'b0);
    tick();
    irq_chk("mask unmask irq later", 1'b0);
    bus_write(ADDR_CTRL, 32'h0);

    // ---- Mid-count disable, then re-enable with a new PRESET ----
    bus_write(ADDR_PRESET, 32'd10);
    bus_write(ADDR_CTRL, 32'h1);
    repeat (5) tick();
    read_chk("midcount count before disable", ADDR_COUNT, 32'd7);
    // This write lands on the edge that makes COUNT=6.
    bus_write(ADDR_CTRL, 32'h0);
    read_chk("midcount count at disable", ADDR_COUNT, 32'd6);
    for (int i = 0; i < 3; i++) begin
      tick();
      read_chk($sformatf("midcount count held[%0d]", i), ADDR_COUNT, 32'd6);
    end
    bus_write(ADDR_PRESET, 32'd4);
    bus_write(ADDR_CTRL, 32'h1);
    tick();
    tick();
    read_chk("midcount reload", ADDR_COUNT, 32'd4);
    bus_write(ADDR_CTRL, 32'h0);
    tick();

    // ---- Expiry coinciding with a CTRL write, then reset mid-count ----
    bus_write(ADDR_PRESET, 32'd10);
    bus_write(ADDR_CTRL, 32'h9);
    t = 0;
    while (irq !== 1'b1 && t < 40) begin
      tick();
      t++;
    end
    check32("rstmid irq latency", 32'(t), 32'd13);
    // Written during INT: CPU EN=1 wins, pending set wins over write-clear.
    bus_write(ADDR_CTRL, 32'h9);
    irq_chk("rstmid pending survives ctrl write", 1'b1);
    read_chk("rstmid ctrl cpu wins", ADDR_CTRL, 32'h9);
    addr = ADDR_COUNT;
    t = 0;
    #1;
    while (rd !== 32'd5 && t < 40) begin
      tick();
      t++;
    end
    read_chk("rstmid count reached 5", ADDR_COUNT, 32'd5);
    irq_chk("rstmid irq before reset", 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    all_zero_chk("rstmid");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_timer_dev
`default_nettype wire

// File: doc/timer_dev.md
Name: timer_dev

Overview:
- Memory-mapped countdown timer on the CPU's data-side system bus, downstream of the pipeline memory stage.
- The bus bridge decodes the store/load address and drives sel/we/addr/wd; rd is returned for loads.
- The timer raises an interrupt request when the count expires.
- Supports one-shot mode and auto-reload mode.

Parameters:
CNT_W, 32, width of PRESET/COUNT registers and bus data (must be 32 for current bus).

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
sel  input  1  bridge chip-select for this device
we  input  1  write enable (qualified by sel)
addr  input  2  word offset (bus address bits [3:2])
wd  input  32  write data
rd  output  32  read data (combinational)
irq  output  1  interrupt request to CPU

Behaviour:
- Registers by addr:
  - 0 = CTRL: [0] EN, [2:1] MODE, [3] IM; bits [31:4] read 0.
  - 1 = PRESET.
  - 2 = COUNT (read-only).
  - 3 = reserved, reads 0, writes ignored.
- Reset: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_pending=0, irq=0. rd reflects the reset registers.
- Writes take effect at the clock edge when sel&we. Writes to COUNT and reserved are ignored.
- rd = selected register, independent of sel. No read side effects.
- MODE 0 = one-shot; MODE 1 = auto-reload; MODE 2/3 behave as MODE 0.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if CTRL.EN -> LOAD, else stay.
  - LOAD: COUNT<=PRESET -> CNT.
  - CNT: if !CTRL.EN -> IDLE (COUNT held). Else if COUNT==0 -> INT. Else COUNT<=COUNT-1.
  - INT, MODE 0: CTRL.EN<=0, irq_pending<=1 -> IDLE.
  - INT, MODE 1: -> LOAD (irq_pending not set).
- irq = CTRL.IM & ((state==INT) | irq_pending).
  - MODE 1: one-cycle pulse per expiry.
  - MODE 0: high from the INT cycle until cleared.
- irq_pending clears on any CTRL write or reset.
- Simultaneous events:
  - A CTRL write in the same cycle as the FSM's INT clearing of EN: the CPU-written value wins.
  - A CTRL write and irq_pending set in the same cycle: set wins.
- PRESET writes while counting are not seen until the next LOAD.
- Writing CTRL.EN=0 in any state forces IDLE on the edge after the write is visible; COUNT holds its value.
- Re-enable always passes through LOAD (fresh reload); there is no resume.
- PRESET=0: LOAD -> CNT -> INT, so expiry occurs 2 cycles after LOAD.
- Latency: write of EN at edge E0 -> LOAD at E1 -> COUNT=PRESET visible after E2. COUNT reaches 0 after E2+PRESET. INT is entered at E3+PRESET.
- Timing: 32-bit decrement, no wrap. COUNT never decrements below 0.

Decomposition:
- Shared package (timer_pkg): state encodings (IDLE/LOAD/CNT/INT), register offsets (CTRL=0, PRESET=1, COUNT=2), MODE constants (ONESHOT=0, RELOAD=1), CTRL bit positions (EN=0, MODE=2:1, IM=3).
- Single module; no sub-module needed (FSM and register file are small and tightly coupled).

Test Plan:
- One-shot expiry:
  - Stimulus: reset; write PRESET=3; write CTRL=0x9 at E0.
  - Response: COUNT reads 3 after E2, then 2, 1, 0. irq rises after E6 and stays high. CTRL reads 0x8 after E7.
  - Clear: writing CTRL=0x8 drops irq next cycle.
- Auto-reload:
  - Stimulus: PRESET=2, CTRL=0xB.
  - Response: irq is a single-cycle pulse every 5 cycles (LOAD, CNT×3, INT). COUNT cycles 2, 1, 0.
- Mask:
  - Stimulus: PRESET=1, CTRL=0x1 (IM=0).
  - Response: irq stays 0. After expiry CTRL reads 0. Writing CTRL=0x8 keeps irq 0, because the CTRL write cleared pending.
- Mid-count disable/re-enable:
  - Stimulus: PRESET=10, CTRL=0x1; at COUNT=6 write CTRL=0.
  - Response: COUNT holds 6 and state is IDLE.
  - Stimulus: write PRESET=4 then CTRL=0x1.
  - Response: COUNT reloads to 4.
- Reset mid-operation:
  - Stimulus: assert reset while in CNT with COUNT=5 and irq_pending=1.
  - Response: next cycle all registers read 0 and irq=0.
- Bus edge cases:
  - Write COUNT=0x55 -> ignored. Write addr 3 -> reads 0.
  - PRESET=0 with CTRL=0x9 -> irq high 3 cycles after the enable write (E3).
  - we=1 with sel=0 -> no register change.
